rca_seq_adder: RTL and testbench
================================

Name: rca_seq_adder

Overview:
Multi-cycle wide adder controller. It time-multiplexes a single SLICE-bit ripple-carry adder datapath across WIDTH-bit operands, one slice per clock, LSB first. A registered carry links the slices. Valid/ready handshakes on the input and output sides let it sit between producer/consumer stages of the adder exercises and larger arithmetic blocks.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of SLICE, minimum SLICE.
SLICE, 4, width of the shared ripple-carry adder slice.
NSLICE, WIDTH/SLICE, derived local, number of slice steps per operation.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/carry-in presented
in_ready  output  1  controller can accept operands (high only in IDLE)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WIDTH  registered sum
cout  output  1  registered carry-out
out  output  WIDTH+1  {cout, sum}
busy  output  1  high in RUN or DONE
ovf  output  1  signed overflow (see Optional Feature)

Behaviour:
- Reset: already decided — one clock, clk; reset rst_n is asynchronous and active-low. While rst_n=0: state=IDLE; in_ready=1, out_valid=0, busy=0, sum=0, cout=0, out=0, ovf=0; slice counter=0, carry reg=0, operand regs=0.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On the edge where in_valid&&in_ready, capture a, b; carry_reg<=cin; cnt<=0; sum<=0; go to RUN. in_valid with no capture has no effect.
- RUN: in_ready=0. Each cycle:
  - Add a_reg[cnt*SLICE +: SLICE] + b_reg[same] + carry_reg.
  - Write the SLICE-bit result into sum[cnt*SLICE +: SLICE].
  - carry_reg <= slice carry-out.
  - cnt <= cnt+1.
  - At cnt=NSLICE-1: cout <= slice carry-out, go to DONE.
- Latency: out_valid rises exactly NSLICE cycles after the accept edge (4 cycles at default).
- DONE: out_valid=1. sum, cout, out and ovf are held stable until out_valid&&out_ready at an edge, then go to IDLE (in_ready=1 the next cycle). No new operand is accepted in the same cycle as result handoff.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE; held operands are not re-sampled.
- Arithmetic: {cout,sum} == a + b + cin (unsigned, WIDTH+1 bits) for all inputs. Full carry propagation across slice boundaries is required.
- Intermediate sum bits are visible during RUN but are only defined as valid when out_valid=1.
- Reset mid-operation (RUN or DONE): immediate abort to reset values. The in-flight result is discarded and no out_valid is emitted.

Optional Feature:
Macro RCA_SEQ_OVF_EN.
- Defined: ovf is computed in the last RUN cycle as (a_reg[WIDTH-1]==b_reg[WIDTH-1]) && (final sum MSB != a_reg[WIDTH-1]). It is registered, valid with out_valid, and held in DONE.
- Undefined: ovf is tied to 0 and no overflow logic is synthesized. The port still exists.

Test Plan:
All scenarios use WIDTH=16, SLICE=4.
1. Basic add with slice carries: a=16'hAAAA, b=16'hCCCC, cin=0 -> after 4 cycles out_valid=1, sum=16'h7776, cout=1, out=17'h17776.
2. Full-width carry ripple: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1. Then a=16'hFFFF, b=16'h0001, cin=0 -> same result.
3. Backpressure: a=16'h1234, b=16'h1111 with out_ready=0 for 3 cycles -> out_valid, sum=16'h2345 and cout=0 held stable; in_ready=0 throughout. After out_ready=1 -> IDLE, in_ready=1 next cycle.
4. Overflow (macro on): a=16'h7FFF, b=16'h0001 -> sum=16'h8000, cout=0, ovf=1. Same stimulus with macro off -> ovf=0.
5. Reset mid-run: accept a=16'h0F0F, b=16'h0101, assert rst_n=0 after 2 RUN cycles -> all outputs immediately 0, in_ready=1; after release no out_valid without a new accept.
6. Ignored input: in_valid pulsed with new operands during RUN -> result still matches the first accepted operands; back-to-back operations (accept on the cycle after handoff) both produce correct results.

Source files
------------

// File: rtl/rca_seq_adder.sv
// Sequential wide adder: one shared SLICE-bit ripple-carry slice is reused NSLICE times, LSB slice first.
// Latency: out_valid rises NSLICE cycles after the accept edge; in_ready is high only in IDLE.
// Backpressure: the result is held in DONE until out_ready; optional signed overflow via macro RCA_SEQ_OVF_EN.
module rca_seq_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH:0]   out,
    output logic             busy,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic [SLICE-1:0] w_a_slc;
    logic [SLICE-1:0] w_b_slc;
    logic [SLICE:0]   w_slc;
    logic             w_accept;
    logic             w_last;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);

    // Pick the operand slice addressed by the step counter.
    always_comb begin
        w_a_slc = '0;
        w_b_slc = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (r_cnt == CW'(i)) begin
                w_a_slc = r_a[i*SLICE +: SLICE];
                w_b_slc = r_b[i*SLICE +: SLICE];
            end
        end
    end

    // The shared slice: top bit is the carry handed to the next step.
    assign w_slc = {1'b0, w_a_slc} + {1'b0, w_b_slc} + {{SLICE{1'b0}}, r_carry};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: accept only in IDLE, hand off only in DONE, so the two never coincide.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture and one slice step per RUN cycle; results are frozen outside RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_sum   <= '0;
            r_carry <= cin;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            for (int i = 0; i < NSLICE; i++) begin
                if (r_cnt == CW'(i)) begin
                    r_sum[i*SLICE +: SLICE] <= w_slc[SLICE-1:0];
                end
            end
            r_carry <= w_slc[SLICE];
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_slc[SLICE];
            end
        end
    end

`ifdef RCA_SEQ_OVF_EN
    logic r_ovf;

    // Signed overflow: like-signed operands whose final sum MSB (last slice's top bit) flips sign.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_slc[SLICE-1] != r_a[WIDTH-1]);
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign out       = {r_cout, r_sum};

endmodule

// File: tb/tb_rca_seq_adder.sv
// Bench for rca_seq_adder (WIDTH=16, SLICE=4): vector table plus reset/ignored-input/back-to-back sequences.
// Expected results are queued at each accept and popped at each result handoff.
// Overflow expectations follow RCA_SEQ_OVF_EN as the design is built.
module tb_rca_seq_adder;

    localparam int NSLICE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic [16:0] out;
    logic        busy;
    logic        ovf;

    rca_seq_adder #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .out(out), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          hold;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ovf_model(input logic [15:0] x, input logic [15:0] y, input logic [15:0] s);
`ifdef RCA_SEQ_OVF_EN
        return (x[15] == y[15]) && (s[15] != x[15]);
`else
        return 1'b0;
`endif
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vc, input logic vovf);
        exp_t e;
        int   t;
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        acc_cyc = cyc + 1;
        {e.cout, e.sum} = {1'b0, va} + {1'b0, vb} + {16'd0, vc};
`ifdef RCA_SEQ_OVF_EN
        e.ovf = vovf;
`else
        e.ovf = 1'b0;
`endif
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
    endtask

    // Waits for out_valid, holds out_ready low for 'hold' cycles, then hands the result off.
    task automatic collect(input string tag, input int hold);
        exp_t e;
        int   t;
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_latency"}, cyc - acc_cyc, NSLICE);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: got empty queue expected an entry", tag);
            return;
        end
        e = sb.pop_front();
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_inrdy"}, in_ready, 0);
            check({tag, "_hold_sum"}, sum, e.sum);
            @(negedge clk);
        end
        check({tag, "_sum"}, sum, e.sum);
        check({tag, "_cout"}, cout, e.cout);
        check({tag, "_out"}, out, {e.cout, e.sum});
        check({tag, "_ovf"}, ovf, e.ovf);
        check({tag, "_busy"}, busy, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_valid"}, out_valid, 0);
        check({tag, "_post_inrdy"}, in_ready, 1);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{16'hAAAA, 16'hCCCC, 1'b0, 16'h7776, 1'b1, 1'b0, 0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1};
        vecs[3] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 3};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 2};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out", out, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors; the table's expectations are also cross-checked against the plain sum model.
        foreach (vecs[i]) begin
            check($sformatf("v%0d_table", i), {vecs[i].cout, vecs[i].sum},
                  {1'b0, vecs[i].a} + {1'b0, vecs[i].b} + {16'd0, vecs[i].cin});
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].ovf);
            collect($sformatf("v%0d", i), vecs[i].hold);
        end

        // New operands pulsed during RUN must be ignored.
        send(16'h0123, 16'h0456, 1'b0, 1'b0);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
        check("ign_inrdy", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        collect("ign", 0);

        // Back-to-back: next accept on the cycle right after handoff.
        send(16'hBEEF, 16'h4111, 1'b1, 1'b0);
        collect("b2b0", 0);
        send(16'h00FF, 16'h0001, 1'b0, 1'b0);
        collect("b2b1", 0);

        // Random operations, with the model computing all expectations.
        for (int i = 0; i < 6; i++) begin
            logic [15:0] ra, rb;
            logic        rc;
            logic [15:0] rs;
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            rs = ra + rb + {15'd0, rc};
            send(ra, rb, rc, ovf_model(ra, rb, rs));
            collect($sformatf("rnd%0d", i), i % 3);
        end

        // Reset after two RUN cycles aborts the operation with no result.
        send(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_inrdy", in_ready, 1);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out", out, 0);
        check("mid_rst_ovf", ovf, 0);
        void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("mid_rst_no_result", seen, 0);
        end
        send(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        collect("after_rst", 0);

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
